bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
Multi-cycle adder for two WIDTH-bit operands. It processes one bit per clock, LSB first, through the team's single-bit mux-based full-adder cell. A flip-flop holds the carry between bits. The block sits directly upstream of the full-adder cell: each cycle it sequences operand bits and the carry into the cell, then collects the cell's sum and carry outputs into a result word, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; captured on the edge that accepts start
b  input  WIDTH  operand B; captured on the edge that accepts start
cin  input  1  initial carry-in; captured with a/b
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when sum/cout are updated
sum  output  WIDTH  result a+b+cin modulo 2^WIDTH (registered)
cout  output  1  carry out of bit WIDTH-1 (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, bit counter and carry flip-flop are all cleared.
- State machine: IDLE, ADD, DONE.
- IDLE, start=1: on the edge, load a_sr<=a, b_sr<=b, carry<=cin, count<=0; go to ADD. busy=1 from the next cycle.
- IDLE, start=0: stay in IDLE.
- ADD, per edge: the cell inputs are x=a_sr[0], y=b_sr[0], cin=carry.
  - carry<=cell carry.
  - acc shifts right with the cell sum entering at bit WIDTH-1.
  - a_sr and b_sr shift right.
  - count<=count+1.
- ADD, edge where count==WIDTH-1 (last bit): sum<=final acc value including this bit; cout<=cell carry; go to DONE.
- DONE: done=1, busy=0, for exactly one cycle. If start=1 in this cycle, it is accepted exactly as in IDLE and the FSM goes to ADD. Otherwise the FSM goes to IDLE.
- Latency: done rises exactly WIDTH rising edges after the edge that accepts start. busy is high for exactly WIDTH cycles.
- Output hold: sum and cout change only on the completing edge and on reset. They hold the last result through IDLE and through the next operation.
- busy and done are never high together. done is never high for two consecutive cycles unless two operations complete back-to-back, and those are separated by WIDTH cycles.
- start while busy=1 is ignored. It is not queued.
- Changes to a, b or cin after acceptance have no effect on the result.
- Reset during ADD aborts the operation immediately (asynchronous): no done pulse, and sum/cout return to 0. A start after reset release behaves normally.
- Width rules:
  - count is clog2(WIDTH)+1 bits wide.
  - Overflow is reported only via cout; sum wraps modulo 2^WIDTH.
  - WIDTH=1 gives a single ADD cycle.
- Per-bit arithmetic:
  - cell sum = x XOR y XOR cin.
  - cell carry = majority(x, y, cin).

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> busy=0, done=0, sum=8'h00, cout=0 without waiting for a clock edge.
- Basic add and latency: WIDTH=8, a=8'h2D, b=8'h1B, cin=0 -> sum=8'h48, cout=0. done rises on the 8th edge after acceptance, is high for 1 cycle, and busy is high for 8 cycles.
- Carry chain cases:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Ignored inputs: during busy, pulse start with a=8'h55, and change a/b/cin mid-operation -> the result still matches the originally captured operands, and no second operation runs.
- Abort: assert rst after 3 ADD cycles -> outputs 0 and no done pulse. Then start a=8'h10, b=8'h20, cin=0 -> sum=8'h30 after 8 cycles.
- Back-to-back: hold start=1 in the DONE cycle with new operands a=8'h80, b=8'h80 -> accepted with no gap. Previous sum holds until the second done, then sum=8'h00, cout=1.

Source files
------------

// File: rtl/bit_serial_adder.sv
// bit_serial_adder
//   Multi-cycle adder: adds two WIDTH-bit operands plus a carry-in, one bit
//   per clock, LSB first, through a mux-based full-adder cell. A flip-flop
//   carries between bits; the per-bit sums are shifted into an accumulator
//   and published to sum/cout on the completing edge.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, honoured only when busy=0
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   initial carry-in, captured with a/b
//   busy   out  high for the WIDTH cycles of bit processing
//   done   out  one-cycle pulse when sum/cout have just been updated
//   sum    out  registered (a+b+cin) mod 2^WIDTH
//   cout   out  registered carry out of bit WIDTH-1

// Single-bit full adder built from 2:1 muxes. The propagate term selects
// between inverted/straight carry-in for the sum, and between carry-in and
// x (generate/kill case) for the carry.
module full_adder_mux (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = x ^ y;
  assign s  = p ? ~ci : ci;
  assign co = p ? ci  : x;
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             accept;
  logic             last;
  logic             cell_s;
  logic             cell_co;

  full_adder_mux u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Shift-based form keeps the insertion legal for WIDTH=1 as well.
  assign acc_next = (acc >> 1) | ({{(WIDTH-1){1'b0}}, cell_s} << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus accept/last-bit strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADD;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ADD: begin
        if (count == LAST) begin
          state_next = DONE;
          last       = 1'b1;
        end else begin
          state_next = ADD;
        end
      end
      DONE: begin
        // A start in the done cycle is taken immediately, no idle gap.
        if (start) begin
          state_next = ADD;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting and carry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      acc   <= '0;
      count <= '0;
      carry <= cin;
    end else if (state == ADD) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= acc_next;
      count <= count + CW'(1);
      carry <= cell_co;
    end else begin
      a_sr  <= a_sr;
      b_sr  <= b_sr;
      acc   <= acc;
      count <= count;
      carry <= carry;
    end
  end

  // Result registers: updated only on the completing edge, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= acc_next;
      cout <= cell_co;
    end else begin
      sum  <= sum;
      cout <= cout;
    end
  end

  // Handshake outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == ADD);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors;
  int checks;
  int done_seen;

  // expected {cout, sum} per issued operation
  logic [W:0] exp_q [$];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      check("busy_done_exclusive", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {23'd0, cout, sum}, {23'd0, e});
      end
    end
  end

  // Present operands at the negedge and let the next posedge accept them.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W:0] expv, input bit push);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done; checks latency with a bound.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3*W) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, W);
  endtask

  initial begin
    errors = 0; checks = 0; done_seen = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum",  {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic add with cycle-by-cycle busy/done profile.
    issue(8'h2D, 8'h1B, 1'b0, {1'b0, 8'h48}, 1'b1);
    check("basic_busy_0", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i < W) begin
        check("basic_busy", {31'd0, busy}, 32'd1);
        check("basic_nodone", {31'd0, done}, 32'd0);
      end else begin
        check("basic_busy_end", {31'd0, busy}, 32'd0);
        check("basic_done", {31'd0, done}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    check("basic_done_pulse", {31'd0, done}, 32'd0);
    check("basic_hold", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h48});

    // Carry chain cases.
    issue(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00}, 1'b1);
    wait_done("ff_01");
    issue(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, 1'b1);
    wait_done("ff_ff_c");
    issue(8'h00, 8'h00, 1'b1, {1'b0, 8'h01}, 1'b1);
    wait_done("00_00_c");

    // Inputs ignored while busy; start pulse is not queued.
    issue(8'h33, 8'h44, 1'b1, {1'b0, 8'h78}, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_second_op_busy", {31'd0, busy}, 32'd0);
    check("no_second_op_count", done_seen, 5);
    check("ignored_hold", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h78});

    // Abort after three ADD cycles with an asynchronous mid-cycle reset.
    issue(8'h12, 8'h34, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {23'd0, cout, sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, 5);
    issue(8'h10, 8'h20, 1'b0, {1'b0, 8'h30}, 1'b1);
    wait_done("post_abort");

    // Back-to-back: new start accepted in the DONE cycle.
    issue(8'h11, 8'h22, 1'b0, {1'b0, 8'h33}, 1'b1);
    wait_done("b2b_first");
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      check("b2b_hold", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h33});
    end
    @(posedge clk);
    #1;
    check("b2b_second_done", {31'd0, done}, 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_total", done_seen, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
